// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back always wins, and long-latency results
// go through a two-entry buffer with WAW squash. Define WB_ARB_STALL_EN to enable starvation stalls.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_wreg,
    input  logic [4:0]  wb_wd,
    input  logic [31:0] wb_wdata,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wd,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stallreq
);

    logic [1:0]  count_q, count_d;
    logic [1:0]  v_q, v_d;
    logic [4:0]  wd_q   [2];
    logic [4:0]  wd_d   [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];

    logic lu_xfer, lu_keep, enq, deq, wr_idx;

    assign lu_ready = !rst && (count_q < 2'd2);
    assign lu_xfer  = lu_valid && lu_ready;
    assign lu_keep  = lu_xfer && (lu_wd != 5'd0);
    assign deq      = !wb_wreg && (count_q != 2'd0);
    assign enq      = lu_keep && (wb_wreg || count_q != 2'd0);
    // After a pop the remaining entry sits in slot 0, so a new result lands behind it.
    assign wr_idx   = (count_q == 2'd1) && !deq;
    assign count_d  = count_q + {1'b0, enq} - {1'b0, deq};

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (wb_wreg) begin
                rf_we    = 1'b1;
                rf_waddr = wb_wd;
                rf_wdata = wb_wdata;
            end else if (count_q != 2'd0) begin
                rf_we    = v_q[0];
                rf_waddr = v_q[0] ? wd_q[0] : 5'd0;
                rf_wdata = v_q[0] ? data_q[0] : 32'd0;
            end else if (lu_keep) begin
                rf_we    = 1'b1;
                rf_waddr = lu_wd;
                rf_wdata = lu_wdata;
            end
        end
    end

    always_comb begin
        v_d    = v_q;
        wd_d   = wd_q;
        data_d = data_q;
        for (int i = 0; i < 2; i++) begin
            if (wb_wreg && v_q[i] && wd_q[i] == wb_wd) begin
                v_d[i] = 1'b0;
            end
        end
        if (deq) begin
            v_d[0]    = v_d[1];
            wd_d[0]   = wd_d[1];
            data_d[0] = data_d[1];
            v_d[1]    = 1'b0;
        end
        // Enqueue after squash so a same-cycle result to the same register survives.
        if (enq) begin
            v_d[wr_idx]    = 1'b1;
            wd_d[wr_idx]   = lu_wd;
            data_d[wr_idx] = lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            v_q     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                wd_q[i]   <= 5'd0;
                data_q[i] <= 32'd0;
            end
        end else begin
            count_q <= count_d;
            v_q     <= v_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
        end
    end

`ifdef WB_ARB_STALL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_STALL} state_t;

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;

    always_comb begin
        state_d  = state_q;
        starve_d = 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (count_d != 2'd0) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (count_d == 2'd0) begin
                    state_d = ST_IDLE;
                end else if (!deq && v_q[0]) begin
                    if (starve_q == STARVE_LAST) state_d = ST_STALL;
                    else                         starve_d = starve_q + 4'd1;
                end else if (!deq) begin
                    starve_d = starve_q;
                end
            end
            ST_STALL: begin
                if (count_d == 2'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign stallreq = (state_q == ST_STALL) && !rst;
`else
    assign stallreq = 1'b0;
    // The starvation limit has no effect without the stall logic.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_unused
    end
`endif

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive PEND cycles with head not drained before stall is requested (range 1..15).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset (`RstEnable` level).
REQ-004 wb_wreg  input  1  pipeline write-back write enable.
REQ-005 wb_wd  input  5  pipeline write-back destination register.
REQ-006 wb_wdata  input  32  pipeline write-back data.
REQ-007 lu_valid  input  1  long-latency unit result valid.
REQ-008 lu_wd  input  5  long-latency result destination register.
REQ-009 lu_wdata  input  32  long-latency result data.
REQ-010 lu_ready  output  1  arbiter accepts lu result this cycle (transfer = lu_valid & lu_ready).
REQ-011 rf_we / rf_waddr / rf_wdata  output  1/5/32  single regfile write port.
REQ-012 stallreq  output  1  registered stall request to pipeline control.

Function
REQ-013 Two-entry FIFO of {valid, wd[4:0], wdata[31:0]}, 2-bit count; lu_ready = (count < 2), no same-cycle pass-through when full.
REQ-014 Pipeline has absolute priority: wb_wreg=1 -> rf_we=1, rf_waddr=wb_wd, rf_wdata=wb_wdata, same cycle (zero latency).
REQ-015 wb_wreg=0, count=0, lu_valid=1 -> lu result written directly same cycle, not buffered.
REQ-016 wb_wreg=0, count>0 -> FIFO head drained to port; lu result accepted same cycle is enqueued behind it.
REQ-017 wb_wreg=1 and lu transfer -> lu result enqueued.
REQ-018 lu transfer with lu_wd=0 -> accepted and discarded, never written, never enqueued.
REQ-019 WAW squash: pipeline write with wb_wd equal to a valid buffered entry's wd clears that entry's valid bit; matching lu result enqueued same cycle is not squashed.
REQ-020 Invalid head pops in one cycle without asserting rf_we; port is then free for a direct lu write only if count becomes 0 next cycle.
REQ-021 FSM: IDLE (count=0), PEND (count>0, stallreq=0), STALL (stallreq=1).
REQ-022 IDLE->PEND on enqueue; PEND->IDLE when count reaches 0.
REQ-023 starve_cnt (4 bits) increments each PEND cycle where a valid head is not drained, clears on drain or leaving PEND.
REQ-024 PEND->STALL when starve_cnt == STARVE_LIMIT-1 and head again not drained; stallreq=1 from next cycle.
REQ-025 STALL: pipeline control guarantees wb_wreg=0; one head drained per cycle; STALL->IDLE when count reaches 0, stallreq=0 the following cycle.
REQ-026 STALL with wb_wreg=1 (contract violation): pipeline still wins, head held, state stays STALL.
REQ-027 Simultaneous enqueue and dequeue at count=1 -> count stays 1, order preserved.

Reset
REQ-028 rst=1 at rising edge: FIFO emptied, valid bits cleared, starve_cnt=0, state=IDLE, stallreq=0.
REQ-029 While rst=1: rf_we=0, rf_waddr=0 (`NOPRegAddr`), rf_wdata=0 (`ZeroWord`), lu_ready=0, stallreq=0.
REQ-030 Reset mid-STALL or with buffered entries discards them without any write.

Configuration
REQ-031 Macro WB_ARB_STALL_EN defined: STALL state, starve_cnt and stallreq behave per REQ-023..026.
REQ-032 WB_ARB_STALL_EN undefined: no STALL state or starve_cnt, stallreq tied 0, buffer drains only in cycles with wb_wreg=0.

Verification
REQ-033 wb_wreg=1, wb_wd=3, wb_wdata=0x11 with lu_valid=1, lu_wd=4, lu_wdata=0x22 -> cycle0 writes r3=0x11, next idle cycle writes r4=0x22.
REQ-034 Two lu results (r5, r6) during continuous wb_wreg=1 -> lu_ready=0 on third lu_valid, count=2, no loss.
REQ-035 STARVE_LIMIT=4, one buffered entry, wb_wreg=1 held -> stallreq=1 after 4 undrained PEND cycles; with wb_wreg=0 then, entry drained, stallreq=0 next cycle.
REQ-036 Buffer r7=0xAA, then pipeline writes r7=0xBB -> r7 final value 0xBB, no rf_we for 0xAA.
REQ-037 lu_valid with lu_wd=0 -> lu_ready=1, rf_we=0, count unchanged.
REQ-038 rst asserted in STALL with count=2 -> next cycle state IDLE, count=0, stallreq=0, no write.
